// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box table, state type and FSM states
// used by the iterative SubBytes engine.
package aes_pkg;

  localparam int AES_NUM_BYTES = 16;

  typedef logic [0:127] aes_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sbs_state_e;

  // Standard FIPS-197 forward S-box, indexed by the input byte value
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Request/result bundle between the round controller (master) and the
// SubBytes engine (slave).
interface sub_bytes_seq_if;
  import aes_pkg::*;

  logic       start;
  aes_state_t a;
  logic       busy;
  logic       done;
  aes_state_t b;

  modport master (output start, output a, input busy, input done, input b);
  modport slave  (input start, input a, output busy, output done, output b);

endinterface

// File: rtl/sbox_fwd.sv
// Single-byte combinational forward S-box lookup.
module sbox_fwd
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative forward SubBytes: substitutes BYTES_PER_CYCLE bytes of the captured
// state per clock and publishes the whole result with a one-cycle done pulse.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  sub_bytes_seq_if.slave bus
);

  localparam int NUM_GRPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int GRP_W    = (NUM_GRPS > 1) ? $clog2(NUM_GRPS) : 1;
  localparam int GRP_BITS = 8 * BYTES_PER_CYCLE;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GRPS - 1);

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  sbs_state_e           r_state, w_stateNext;
  logic [GRP_W-1:0]     r_grp, w_grpNext;
  aes_state_t           r_work, w_workNext;
  aes_state_t           r_b, w_bNext;
  logic                 r_done, w_doneNext;
  aes_state_t           w_workSub;
  logic [0:GRP_BITS-1]  w_grpIn;
  logic [0:GRP_BITS-1]  w_grpOut;
  int                   w_base;

  assign w_base  = int'(r_grp) * GRP_BITS;
  assign w_grpIn = r_work[w_base +: GRP_BITS];

  generate
    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
      sbox_fwd u_sbox (
        .i_byte (w_grpIn[8*j +: 8]),
        .o_byte (w_grpOut[8*j +: 8])
      );
    end
  endgenerate

  // Work register with the current group replaced by its substituted bytes
  always_comb begin
    w_workSub = r_work;
    w_workSub[w_base +: GRP_BITS] = w_grpOut;
  end

  always_comb begin
    w_stateNext = r_state;
    w_grpNext   = r_grp;
    w_workNext  = r_work;
    w_bNext     = r_b;
    w_doneNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_workNext  = bus.a;
          w_grpNext   = '0;
          w_stateNext = BUSY;
        end
      end
      BUSY: begin
        w_workNext = w_workSub;
        if (r_grp == LAST_GRP) begin
          w_bNext     = w_workSub;
          w_doneNext  = 1'b1;
          w_grpNext   = '0;
          w_stateNext = IDLE;
        end else begin
          w_grpNext = r_grp + GRP_W'(1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grp   <= '0;
      r_work  <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_grp   <= w_grpNext;
      r_work  <= w_workNext;
      r_b     <= w_bNext;
      r_done  <= w_doneNext;
    end
  end

  assign bus.busy = (r_state == BUSY);
  assign bus.done = r_done;
  assign bus.b    = r_b;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: one engine per legal BYTES_PER_CYCLE,
// expected results taken from hand-looked-up S-box values and FIPS-197 App. B.
module tb_sub_bytes_seq;
  import aes_pkg::*;

  localparam aes_state_t ZEROS = {16{8'h00}};
  localparam aes_state_t ALL53 = {16{8'h53}};
  localparam aes_state_t ALLFF = {16{8'hff}};
  localparam aes_state_t ALL63 = {16{8'h63}};
  localparam aes_state_t ALLED = {16{8'hed}};
  localparam aes_state_t ALL16 = {16{8'h16}};
  localparam aes_state_t FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam aes_state_t FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  aes_state_t tbA = '0;
  logic       startV [5] = '{default: 1'b0};
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  sub_bytes_seq_if if1 ();
  sub_bytes_seq_if if2 ();
  sub_bytes_seq_if if4 ();
  sub_bytes_seq_if if8 ();
  sub_bytes_seq_if if16 ();

  assign if1.start  = startV[0];
  assign if2.start  = startV[1];
  assign if4.start  = startV[2];
  assign if8.start  = startV[3];
  assign if16.start = startV[4];
  assign if1.a  = tbA;
  assign if2.a  = tbA;
  assign if4.a  = tbA;
  assign if8.a  = tbA;
  assign if16.a = tbA;

  sub_bytes_seq #(.BYTES_PER_CYCLE(1))  dut1  (.clk(clk), .reset_n(reset_n), .bus(if1));
  sub_bytes_seq #(.BYTES_PER_CYCLE(2))  dut2  (.clk(clk), .reset_n(reset_n), .bus(if2));
  sub_bytes_seq #(.BYTES_PER_CYCLE(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(if4));
  sub_bytes_seq #(.BYTES_PER_CYCLE(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));
  sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(if16));

  function automatic aes_state_t getB(input int sel);
    case (sel)
      0: return if1.b;
      1: return if2.b;
      2: return if4.b;
      3: return if8.b;
      default: return if16.b;
    endcase
  endfunction

  function automatic logic getBusy(input int sel);
    case (sel)
      0: return if1.busy;
      1: return if2.busy;
      2: return if4.busy;
      3: return if8.busy;
      default: return if16.busy;
    endcase
  endfunction

  function automatic logic getDone(input int sel);
    case (sel)
      0: return if1.done;
      1: return if2.done;
      2: return if4.done;
      3: return if8.done;
      default: return if16.done;
    endcase
  endfunction

  // Compare one observed value against its required value and tally the result
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one clock on engine sel; returns just after the start edge
  task automatic applyStimulus(input int sel, input aes_state_t vec);
    tbA = vec;
    startV[sel] = 1'b1;
    @(negedge clk);
    startV[sel] = 1'b0;
  endtask

  task automatic waitDone(input int sel, output int lat);
    lat = 0;
    while (getDone(sel) !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runVector(input string tag, input int sel, input aes_state_t vec,
                           input aes_state_t exp);
    int lat;
    applyStimulus(sel, vec);
    checkOutput({tag, "_busy"}, getBusy(sel), 1'b1);
    waitDone(sel, lat);
    checkOutput({tag, "_latency"}, lat, 16 >> sel);
    checkOutput({tag, "_busyAtDone"}, getBusy(sel), 1'b0);
    checkOutput({tag, "_b"}, getB(sel), exp);
    @(negedge clk);
    checkOutput({tag, "_doneOneCycle"}, getDone(sel), 1'b0);
  endtask

  initial begin
    aes_state_t prevB;
    aes_state_t bAtDone;
    int         lat;
    int         doneCnt;
    int         doneEdge;
    logic       held;
    logic       doneSeen;

    $display("[TB] reset");
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", if4.busy, 1'b0);
    checkOutput("rst_done", if4.done, 1'b0);
    checkOutput("rst_b", if4.b, ZEROS);
    checkOutput("rst_b_bpc1", if1.b, ZEROS);
    reset_n = 1'b1;
    doneSeen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (if4.done !== 1'b0) doneSeen = 1'b1;
    end
    checkOutput("noStartNoDone", doneSeen, 1'b0);

    $display("[TB] single vectors, 4 bytes/cycle");
    runVector("zeros", 2, ZEROS, ALL63);
    runVector("all53", 2, ALL53, ALLED);
    runVector("allFF", 2, ALLFF, ALL16);

    $display("[TB] FIPS-197 round 1 SubBytes for every group size");
    runVector("fips_bpc1", 0, FIPS_IN, FIPS_OUT);
    runVector("fips_bpc2", 1, FIPS_IN, FIPS_OUT);
    runVector("fips_bpc4", 2, FIPS_IN, FIPS_OUT);
    runVector("fips_bpc8", 3, FIPS_IN, FIPS_OUT);
    runVector("fips_bpc16", 4, FIPS_IN, FIPS_OUT);

    $display("[TB] start ignored while busy");
    prevB = getB(2);
    applyStimulus(2, ZEROS);
    @(negedge clk);
    tbA = ALLFF;
    startV[2] = 1'b1;
    @(negedge clk);
    startV[2] = 1'b0;
    checkOutput("rej_holdAtSecondStart", if4.b, prevB);
    doneCnt = 0;
    doneEdge = -1;
    held = 1'b1;
    bAtDone = '0;
    for (int e = 3; e <= 14; e++) begin
      @(negedge clk);
      if (if4.done === 1'b1) begin
        doneCnt++;
        if (doneEdge < 0) begin
          doneEdge = e;
          bAtDone = if4.b;
        end
      end else if (doneCnt == 0 && if4.b !== prevB) begin
        held = 1'b0;
      end
    end
    checkOutput("rej_doneCount", doneCnt, 1);
    checkOutput("rej_doneEdge", doneEdge, 4);
    checkOutput("rej_bHeld", held, 1'b1);
    checkOutput("rej_bAtDone", bAtDone, ALL63);
    checkOutput("rej_bAfter", if4.b, ALL63);
    checkOutput("rej_idle", if4.busy, 1'b0);

    $display("[TB] back-to-back");
    applyStimulus(2, ZEROS);
    waitDone(2, lat);
    checkOutput("b2b_first_latency", lat, 4);
    checkOutput("b2b_first_b", if4.b, ALL63);
    applyStimulus(2, ALL53);
    checkOutput("b2b_accepted", if4.busy, 1'b1);
    checkOutput("b2b_doneDropped", if4.done, 1'b0);
    checkOutput("b2b_firstHeld", if4.b, ALL63);
    @(negedge clk);
    checkOutput("b2b_firstHeldLater", if4.b, ALL63);
    lat = 1;
    while (if4.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_second_latency", lat, 4);
    checkOutput("b2b_second_b", if4.b, ALLED);

    $display("[TB] reset during operation, 1 byte/cycle");
    @(negedge clk);
    applyStimulus(0, FIPS_IN);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midRst_b", if1.b, ZEROS);
    checkOutput("midRst_busy", if1.busy, 1'b0);
    checkOutput("midRst_done", if1.done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    doneSeen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (if1.done !== 1'b0 || if1.busy !== 1'b0) doneSeen = 1'b1;
    end
    checkOutput("midRst_staysIdle", doneSeen, 1'b0);
    runVector("midRst_fresh", 0, ZEROS, ALL63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
